// File: rtl/sequenciador_digilock.sv
// Purpose : DigiLock sequencer: keypad digit capture, password write/verify, failure lockout, unlock hold timer.
// Latency : last verify digit press -> aberto in 3 cycles (edge detect, compare, decide); one memory access per digit.
// Backpressure: none; presses outside OCIOSO/*_ESPERA are dropped. Optional inter-digit timeout: DIGILOCK_TIMEOUT_EN.
module sequenciador_digilock #(
  parameter int N_DIGITOS      = 4,
  parameter int MAX_TENTATIVAS = 3,
  parameter int T_ABERTO       = 500,
  parameter int T_BLOQUEIO     = 1000,
  parameter int T_INTER        = 2000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         modo,
  input  logic                         tecla_ativada,
  input  logic [3:0]                   digito,
  input  logic [3:0]                   mem_rdata,
  output logic [$clog2(N_DIGITOS)-1:0] mem_addr,
  output logic                         mem_wr,
  output logic [3:0]                   mem_wdata,
  output logic                         aberto,
  output logic                         erro,
  output logic                         cfg_ok,
  output logic                         bloqueado,
  output logic                         ocupado
);

  // Index, failure counter and shared timer widths.
  localparam int AW       = $clog2(N_DIGITOS);
  localparam int FW       = $clog2(MAX_TENTATIVAS + 1);
  localparam int T_MAX_AB = (T_ABERTO > T_BLOQUEIO) ? T_ABERTO : T_BLOQUEIO;
  localparam int T_MAX    = (T_INTER > T_MAX_AB) ? T_INTER : T_MAX_AB;
  localparam int TW       = $clog2(T_MAX + 1);

  localparam logic [AW-1:0] IDX_LAST   = AW'(N_DIGITOS - 1);
  localparam logic [FW-1:0] FALHAS_MAX = FW'(MAX_TENTATIVAS);
  localparam logic [TW-1:0] T_ABR_LD   = TW'(T_ABERTO - 1);
  localparam logic [TW-1:0] T_BLQ_LD   = TW'(T_BLOQUEIO - 1);
`ifdef DIGILOCK_TIMEOUT_EN
  localparam logic [TW-1:0] T_INT_LD   = TW'(T_INTER - 1);
`endif

  typedef enum logic [2:0] {
    OCIOSO,
    CFG_GRAVA,
    CFG_ESPERA,
    VER_COMPARA,
    VER_ESPERA,
    VER_DECIDE,
    ABERTO,
    BLOQUEADO
  } estado_t;

  estado_t       state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic [FW-1:0] falhas, falhas_n;
  logic [FW-1:0] falhas_inc;
  logic [TW-1:0] timer, timer_n;
  logic          mismatch, mismatch_n;
  logic          senha_valida, senha_valida_n;
  logic          tecla_q;
  logic [3:0]    dig_r;
  logic          press;

  // A held key yields exactly one press, on its rising edge.
  assign press      = tecla_ativada & ~tecla_q;
  assign falhas_inc = falhas + FW'(1);

  // Key edge tracker and digit capture register; tecla_q follows the key in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tecla_q <= 1'b0;
      dig_r   <= 4'd0;
    end else begin
      tecla_q <= tecla_ativada;
      if (press) begin
        dig_r <= digito;
      end
    end
  end

  // FSM state and datapath registers; a reset mid-sequence aborts it and forgets the password.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= OCIOSO;
      idx          <= '0;
      falhas       <= '0;
      timer        <= '0;
      mismatch     <= 1'b0;
      senha_valida <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      falhas       <= falhas_n;
      timer        <= timer_n;
      mismatch     <= mismatch_n;
      senha_valida <= senha_valida_n;
    end
  end

  // Next-state, datapath updates and strobe outputs.
  always_comb begin
    state_n        = state;
    idx_n          = idx;
    falhas_n       = falhas;
    timer_n        = timer;
    mismatch_n     = mismatch;
    senha_valida_n = senha_valida;
    mem_wr         = 1'b0;
    mem_wdata      = 4'd0;
    erro           = 1'b0;
    cfg_ok         = 1'b0;

    case (state)
      OCIOSO: begin
        // modo is sampled only here; it is ignored for the rest of the sequence.
        if (press) begin
          idx_n = '0;
          if (modo) begin
            state_n = CFG_GRAVA;
          end else begin
            mismatch_n = 1'b0;
            state_n    = VER_COMPARA;
          end
        end
      end

      CFG_GRAVA: begin
        mem_wr    = 1'b1;
        mem_wdata = dig_r;
        if (idx == IDX_LAST) begin
          cfg_ok         = 1'b1;
          senha_valida_n = 1'b1;
          falhas_n       = '0;
          idx_n          = '0;
          state_n        = OCIOSO;
        end else begin
          idx_n   = idx + AW'(1);
          state_n = CFG_ESPERA;
`ifdef DIGILOCK_TIMEOUT_EN
          timer_n = T_INT_LD;
`endif
        end
      end

      CFG_ESPERA: begin
`ifdef DIGILOCK_TIMEOUT_EN
        // An abandoned configuration leaves no usable password behind.
        if (timer == '0) begin
          senha_valida_n = 1'b0;
          idx_n          = '0;
          state_n        = OCIOSO;
        end else if (press) begin
          state_n = CFG_GRAVA;
        end else begin
          timer_n = timer - TW'(1);
        end
`else
        if (press) begin
          state_n = CFG_GRAVA;
        end
`endif
      end

      VER_COMPARA: begin
        // Keep comparing after a mismatch so timing does not leak the failing digit.
        if (dig_r != mem_rdata) begin
          mismatch_n = 1'b1;
        end
        if (idx == IDX_LAST) begin
          state_n = VER_DECIDE;
        end else begin
          idx_n   = idx + AW'(1);
          state_n = VER_ESPERA;
`ifdef DIGILOCK_TIMEOUT_EN
          timer_n = T_INT_LD;
`endif
        end
      end

      VER_ESPERA: begin
`ifdef DIGILOCK_TIMEOUT_EN
        // An abandoned verify counts as a failure and can trigger lockout.
        if (timer == '0) begin
          erro     = 1'b1;
          falhas_n = falhas_inc;
          idx_n    = '0;
          if (falhas_inc == FALHAS_MAX) begin
            timer_n = T_BLQ_LD;
            state_n = BLOQUEADO;
          end else begin
            state_n = OCIOSO;
          end
        end else if (press) begin
          state_n = VER_COMPARA;
        end else begin
          timer_n = timer - TW'(1);
        end
`else
        if (press) begin
          state_n = VER_COMPARA;
        end
`endif
      end

      VER_DECIDE: begin
        idx_n = '0;
        if (!senha_valida) begin
          // No password stored: reject without counting toward lockout.
          erro    = 1'b1;
          state_n = OCIOSO;
        end else if (!mismatch) begin
          falhas_n = '0;
          timer_n  = T_ABR_LD;
          state_n  = ABERTO;
        end else begin
          falhas_n = falhas_inc;
          if (falhas_inc == FALHAS_MAX) begin
            timer_n = T_BLQ_LD;
            state_n = BLOQUEADO;
          end else begin
            erro    = 1'b1;
            state_n = OCIOSO;
          end
        end
      end

      ABERTO: begin
        if (timer == '0) begin
          state_n = OCIOSO;
        end else begin
          timer_n = timer - TW'(1);
        end
      end

      BLOQUEADO: begin
        if (timer == '0) begin
          falhas_n = '0;
          state_n  = OCIOSO;
        end else begin
          timer_n = timer - TW'(1);
        end
      end

      default: begin
        state_n = OCIOSO;
      end
    endcase
  end

  // Level outputs decoded straight from the state register.
  assign mem_addr  = idx;
  assign aberto    = (state == ABERTO);
  assign bloqueado = (state == BLOQUEADO);
  assign ocupado   = (state != OCIOSO);

endmodule
